ct_had_bkpt_sqc_ctrl: RTL

Level-four controller for the two memory breakpoint units (A, B) in HAD. Receives per-unit inst/data breakpoint requests and applies the sequence condition (SQC) from HCR. Raises one debug request toward RTU and holds it until acknowledged. Owns the breakpoint-enable qualifiers fed back to both units and the sticky hit status reported to the HSR.

---
 rtl/ct_had_bkpt_pkg.sv | 13 +
 rtl/ct_had_bkpt_hit_latch.sv | 13 +
 rtl/ct_had_bkpt_sqc_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/ct_had_bkpt_pkg.sv
// ct_had_bkpt_pkg: SQC and state encodings shared by the HAD memory breakpoint sequencer
package ct_had_bkpt_pkg;
  localparam int SQC_W   = 2;
  localparam int STATE_W = 2;
  localparam logic [SQC_W-1:0] SQC_INDEP = 2'b00;
  localparam logic [SQC_W-1:0] SQC_SEQ   = 2'b01;
  localparam logic [SQC_W-1:0] SQC_AND   = 2'b10;
  localparam logic [SQC_W-1:0] SQC_OFF   = 2'b11;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] ST_ARMED = 2'b01;
  localparam logic [STATE_W-1:0] ST_REQ   = 2'b10;
  localparam logic [STATE_W-1:0] ST_DBG   = 2'b11;
endpackage

// File: rtl/ct_had_bkpt_hit_latch.sv
// ct_had_bkpt_hit_latch: sticky hit flag, clear wins over set in the same cycle
module ct_had_bkpt_hit_latch (
  input  logic cpuclk,
  input  logic cpurst_b,
  input  logic set,
  input  logic clr,
  output logic hit
);
  always_ff @(posedge cpuclk or negedge cpurst_b)
    if (!cpurst_b) hit <= 1'b0;
    else if (clr)  hit <= 1'b0;
    else if (set)  hit <= 1'b1;
endmodule

// File: rtl/ct_had_bkpt_sqc_ctrl.sv
// ct_had_bkpt_sqc_ctrl: sequence-condition controller for memory breakpoint units A/B
// Optional external trigger source enabled by HAD_BKPT_EXT_TRIG_EN.
module ct_had_bkpt_sqc_ctrl
  import ct_had_bkpt_pkg::*;
#(
  parameter int SQC_W   = 2,
  parameter int STATE_W = 2
) (
  input  logic               cpuclk,
  input  logic               cpurst_b,
  input  logic               bkpta_inst_req,
  input  logic               bkpta_data_req,
  input  logic               bkptb_inst_req,
  input  logic               bkptb_data_req,
  input  logic               bkpta_ack,
  input  logic               bkptb_ack,
  input  logic [SQC_W-1:0]   regs_xx_sqc,
  input  logic               regs_xx_hcr_wr,
  input  logic               rtu_yy_xx_dbgon,
  input  logic               rtu_had_dbg_ack,
  input  logic               rtu_yy_xx_flush,
`ifdef HAD_BKPT_EXT_TRIG_EN
  input  logic               ext_trig_req,
  output logic               ctrl_regs_hit_ext,
`endif
  output logic               ctrl_bkpta_en,
  output logic               ctrl_bkptb_en,
  output logic               ctrl_rtu_mbkpt_dbgreq,
  output logic               ctrl_regs_hit_a,
  output logic               ctrl_regs_hit_b,
  output logic [STATE_W-1:0] ctrl_regs_sqc_state
);
  logic [STATE_W-1:0] state, nxt;
  logic req_a, req_b, dbgon_q, dbgon_fall, ext, set_a, set_b;
  assign req_a      = bkpta_inst_req | bkpta_data_req;
  assign req_b      = bkptb_inst_req | bkptb_data_req;
  assign dbgon_fall = dbgon_q & ~rtu_yy_xx_dbgon;
`ifdef HAD_BKPT_EXT_TRIG_EN
  assign ext = ext_trig_req && regs_xx_sqc != SQC_OFF && (state == ST_IDLE || state == ST_ARMED);
`else
  assign ext = 1'b0;
`endif
  // set_a/set_b reflect the raw REQ-entry condition; an HCR write in the same cycle clears them away
  always_comb begin
    nxt   = state;
    set_a = 1'b0;
    set_b = 1'b0;
    case (state)
      ST_IDLE: begin
        set_a = (regs_xx_sqc == SQC_INDEP && req_a) || (regs_xx_sqc == SQC_AND && req_a && req_b);
        set_b = (regs_xx_sqc == SQC_INDEP && req_b) || (regs_xx_sqc == SQC_AND && req_a && req_b);
        nxt   = (set_a | set_b | ext) ? ST_REQ : (regs_xx_sqc == SQC_SEQ && req_a) ? ST_ARMED : ST_IDLE;
      end
      ST_ARMED: begin
        set_a = req_b;
        set_b = req_b;
        nxt   = (req_b | ext) ? ST_REQ : ST_ARMED;
      end
      ST_REQ:  nxt = (rtu_had_dbg_ack | rtu_yy_xx_dbgon) ? ST_DBG : ST_REQ;
      default: nxt = dbgon_fall ? ST_IDLE : ST_DBG;
    endcase
    if (regs_xx_hcr_wr && state != ST_REQ) nxt = ST_IDLE;
  end
  always_ff @(posedge cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      state   <= ST_IDLE;
      dbgon_q <= 1'b0;
    end else begin
      state   <= nxt;
      dbgon_q <= rtu_yy_xx_dbgon;
    end
  assign ctrl_bkpta_en         = state == ST_IDLE && regs_xx_sqc != SQC_OFF;
  assign ctrl_bkptb_en         = state == ST_ARMED || (state == ST_IDLE && (regs_xx_sqc == SQC_INDEP || regs_xx_sqc == SQC_AND));
  assign ctrl_rtu_mbkpt_dbgreq = state == ST_REQ;
  assign ctrl_regs_sqc_state   = state;
  ct_had_bkpt_hit_latch u_hit_a (.cpuclk(cpuclk), .cpurst_b(cpurst_b), .set(set_a), .clr(regs_xx_hcr_wr), .hit(ctrl_regs_hit_a));
  ct_had_bkpt_hit_latch u_hit_b (.cpuclk(cpuclk), .cpurst_b(cpurst_b), .set(set_b), .clr(regs_xx_hcr_wr), .hit(ctrl_regs_hit_b));
`ifdef HAD_BKPT_EXT_TRIG_EN
  ct_had_bkpt_hit_latch u_hit_ext (.cpuclk(cpuclk), .cpurst_b(cpurst_b), .set(ext), .clr(regs_xx_hcr_wr), .hit(ctrl_regs_hit_ext));
`endif
  // unit acks are only legal once a debug entry is under way
  a_ack_state: assert property (@(posedge cpuclk) disable iff (!cpurst_b)
    (bkpta_ack | bkptb_ack) |-> (state == ST_REQ || state == ST_DBG));
  a_flush_hold: assert property (@(posedge cpuclk) disable iff (!cpurst_b)
    (state == ST_REQ && rtu_yy_xx_flush && !rtu_had_dbg_ack && !rtu_yy_xx_dbgon) |=> state == ST_REQ);
endmodule
